core_apb_master: RTL and testbench
==================================

# core_apb_master

Parametrised APB master that multiplexes `NUM_PORTS` core-side memory request channels onto one APB bus. It generalises the core's fetch/memory port with round-robin arbitration across concurrent requesters. Request fields are registered, so APB outputs come straight from flops. A transfer timeout is configurable. It sits between the core pipeline stages (fetch, memory, optional page-table walker) and the system APB interconnect.

## Interface
- `NUM_PORTS`, 2: number of requester channels (1..8).
- `ADDR_W`, 32: address width.
- `DATA_W`, 32: data width; strobe width is `DATA_W/8`.
- `TIMEOUT`, 0: number of ACCESS cycles without `pready` before forced error completion; 0 disables the timeout.

Ports:
- `clk` in 1: clock.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in `NUM_PORTS`: per-port request valid.
- `req_ready` out `NUM_PORTS`: per-port completion pulse; at most one bit high at a time.
- `req_addr` in `NUM_PORTS`×`ADDR_W`: per-port address.
- `req_write` in `NUM_PORTS`: per-port write flag.
- `req_wdata` in `NUM_PORTS`×`DATA_W`: per-port write data.
- `req_wstrb` in `NUM_PORTS`×`DATA_W/8`: per-port byte strobes.
- `rsp_rdata` out `DATA_W`: shared read data; valid only with a `req_ready` bit.
- `rsp_err` out 1: shared error; valid only with a `req_ready` bit.
- `psel`, `penable`, `paddr`, `pwrite`, `pwdata`, `pwstrb`: APB master outputs, all registered.
- `pready`, `prdata`, `pslverr`: APB slave inputs.

## Operation
- FSM states: IDLE, SETUP, ACCESS.
- **IDLE**
  - If any `req_valid` bit is set, the arbiter picks the first valid port at or after `rr_ptr`, wrapping modulo `NUM_PORTS`.
  - On the next edge: latch the grant index and that port's addr/write/wdata/wstrb into the APB registers, and go to SETUP.
  - When not writing, `pwdata` and `pwstrb` are still latched from the granted port.
- **SETUP**
  - `psel=1`, `penable=0`; unconditionally go to ACCESS.
- **ACCESS**
  - `psel=1`, `penable=1`.
  - If `pready=1`: `req_ready[grant]=1`, `rsp_rdata=prdata`, `rsp_err=pslverr`. Next state IDLE; `rr_ptr <= grant+1` (mod `NUM_PORTS`).
  - Else if `TIMEOUT>0` and this is the `TIMEOUT`-th consecutive ACCESS cycle: `req_ready[grant]=1`, `rsp_rdata=0`, `rsp_err=1`. Next state IDLE; `rr_ptr` advances the same way.
  - Otherwise stay in ACCESS; the timeout counter increments.
- The timeout counter is `$clog2(TIMEOUT+1)` bits wide and clears on entry to SETUP.
- `req_ready`, `rsp_rdata` and `rsp_err` are combinational from state and APB inputs. Outside an ACCESS completion they are 0.
- Requester contract: hold `req_valid` and all fields stable until `req_ready`.
  - If a requester drops `req_valid` after the grant, the transfer still completes and the `req_ready` pulse is still issued.
  - Changing fields after the grant has no effect on the transfer.
- All ports have equal priority. No port waits more than `NUM_PORTS-1` other transfers.

## Timing
- Reset values: state IDLE, `rr_ptr` 0, counter 0, `psel` 0, `penable` 0, `paddr` 0, `pwrite` 0, `pwdata` 0, `pwstrb` 0, `req_ready` 0, `rsp_rdata` 0, `rsp_err` 0.
- Reset mid-transfer returns to IDLE next edge; no `req_ready` is issued for the aborted transfer.
- Minimum latency: `req_valid` high in IDLE at cycle 0 → SETUP at cycle 1 → ACCESS at cycle 2 → `req_ready` in cycle 2 if `pready=1`.
- Throughput: 3 cycles per transfer minimum, since each completion passes through IDLE.
- If valid requests arrive while busy, they are arbitrated in the next IDLE cycle using the updated `rr_ptr`.
- If `NUM_PORTS=1`, `rr_ptr` is constant 0.

## Structure
- Shared package `core_mem_pkg`:
  - `apb_state_e` (IDLE/SETUP/ACCESS);
  - a `mem_req_t` struct (addr/write/wdata/wstrb), parametrised via localparams `XLEN=32`, `STRB_W=XLEN/8`.
- Sub-module `core_rr_arb`:
  - combinational round-robin picker;
  - inputs: request vector and pointer;
  - outputs: one-hot grant, encoded index and `any` flag.
  - The pointer register stays in `core_apb_master`.

## Test plan
- **Single read**, port 0, addr `0x0000_1000`, `pready=1` in first ACCESS, `prdata=0xDEADBEEF` → `psel` cycles 1–2, `penable` cycle 2, `req_ready=2'b01` in cycle 2, `rsp_rdata=0xDEADBEEF`, `rsp_err=0`.
- **Write with wait states**, port 1, addr `0x2000`, wdata `0x12345678`, wstrb `4'b0011`, `pready` low 3 ACCESS cycles → `paddr`/`pwdata`/`pwstrb` stable throughout, `req_ready=2'b10` on 4th ACCESS cycle.
- **Round-robin fairness**, both ports valid continuously, zero wait → grants alternate 0,1,0,1; each port is served once per 6 cycles.
- **Timeout**, `TIMEOUT=4`, `pready` stuck 0 → `req_ready` on 4th ACCESS cycle with `rsp_err=1`, `rsp_rdata=0`, then IDLE and `psel=0`.
- **Slave error**, `pslverr=1` with `pready=1` → `rsp_err=1` on the completing cycle; the next transfer's `rsp_err` is 0.
- **Reset mid-ACCESS**, `rst=1` for one cycle → next cycle `psel=0`, `penable=0`, `req_ready=0`, `rr_ptr=0`; a pending request is then re-served from SETUP.

Source files
------------

// File: rtl/core_apb_master_pkg.sv
// Shared memory-port types for the core's bus masters.
// Holds the APB master state encoding and the XLEN-wide request bundle.
package core_mem_pkg;

    localparam int XLEN   = 32;
    localparam int STRB_W = XLEN / 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_e;

    typedef struct packed {
        logic [XLEN-1:0]   addr;
        logic              write;
        logic [XLEN-1:0]   wdata;
        logic [STRB_W-1:0] wstrb;
    } mem_req_t;

    // Index width for an n-entry port set; never below one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/core_apb_master_if.sv
// Requester channels plus APB bus of the core APB master.
// master = the bridge itself, slave = requesters and APB target side.
interface core_apb_master_if #(
    parameter int NUM_PORTS = 2,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32
);

    logic [NUM_PORTS-1:0]                  req_valid;
    logic [NUM_PORTS-1:0]                  req_ready;
    logic [NUM_PORTS-1:0][ADDR_W-1:0]      req_addr;
    logic [NUM_PORTS-1:0]                  req_write;
    logic [NUM_PORTS-1:0][DATA_W-1:0]      req_wdata;
    logic [NUM_PORTS-1:0][DATA_W/8-1:0]    req_wstrb;
    logic [DATA_W-1:0]                     rsp_rdata;
    logic                                  rsp_err;

    logic                                  psel;
    logic                                  penable;
    logic [ADDR_W-1:0]                     paddr;
    logic                                  pwrite;
    logic [DATA_W-1:0]                     pwdata;
    logic [DATA_W/8-1:0]                   pwstrb;
    logic                                  pready;
    logic [DATA_W-1:0]                     prdata;
    logic                                  pslverr;

    modport master (
        input  req_valid,
        input  req_addr,
        input  req_write,
        input  req_wdata,
        input  req_wstrb,
        output req_ready,
        output rsp_rdata,
        output rsp_err,
        output psel,
        output penable,
        output paddr,
        output pwrite,
        output pwdata,
        output pwstrb,
        input  pready,
        input  prdata,
        input  pslverr
    );

    modport slave (
        output req_valid,
        output req_addr,
        output req_write,
        output req_wdata,
        output req_wstrb,
        input  req_ready,
        input  rsp_rdata,
        input  rsp_err,
        input  psel,
        input  penable,
        input  paddr,
        input  pwrite,
        input  pwdata,
        input  pwstrb,
        output pready,
        output prdata,
        output pslverr
    );

endinterface

// File: rtl/core_apb_master_rr_arb.sv
// Combinational round-robin picker: first requester at or after i_ptr.
// The pointer register lives in the instantiating master.
module core_rr_arb #(
    parameter int N  = 2,
    parameter int IW = 1
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_ptr,
    output logic [N-1:0]  o_gnt,
    output logic [IW-1:0] o_idx,
    output logic          o_any
);

    int w_k;

    always_comb begin
        o_gnt = '0;
        o_idx = '0;
        o_any = 1'b0;
        w_k   = 0;
        for (int i = 0; i < N; i++) begin
            w_k = (int'(i_ptr) + i) % N;
            if (!o_any && i_req[w_k]) begin
                o_any      = 1'b1;
                o_gnt[w_k] = 1'b1;
                o_idx      = IW'(w_k);
            end
        end
    end

endmodule

// File: rtl/core_apb_master.sv
// APB master multiplexing NUM_PORTS core request channels onto one bus.
// Round-robin grant, registered APB outputs, optional ACCESS timeout.
module core_apb_master
    import core_mem_pkg::*;
#(
    parameter int NUM_PORTS = 2,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int TIMEOUT   = 0
) (
    input  logic               clk,
    input  logic               rst,
    core_apb_master_if.master  bus
);

    localparam int IW = idx_w(NUM_PORTS);
    localparam int SW = DATA_W / 8;
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    localparam logic [CW-1:0] TO_LAST  = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_PORTS - 1);

    apb_state_e            r_state;
    logic [IW-1:0]         r_ptr;
    logic [IW-1:0]         r_idx;
    logic [NUM_PORTS-1:0]  r_gnt;
    logic [CW-1:0]         r_cnt;

    logic                  r_psel;
    logic                  r_penable;
    logic [ADDR_W-1:0]     r_paddr;
    logic                  r_pwrite;
    logic [DATA_W-1:0]     r_pwdata;
    logic [SW-1:0]         r_pwstrb;

    logic [NUM_PORTS-1:0]  w_gnt;
    logic [IW-1:0]         w_idx;
    logic                  w_any;
    logic                  w_access;
    logic                  w_done;
    logic                  w_to;
    logic                  w_fin;
    logic [IW-1:0]         w_ptr_nxt;

    core_rr_arb #(
        .N  (NUM_PORTS),
        .IW (IW)
    ) u_arb (
        .i_req (bus.req_valid),
        .i_ptr (r_ptr),
        .o_gnt (w_gnt),
        .o_idx (w_idx),
        .o_any (w_any)
    );

    assign w_access  = (r_state == ACCESS);
    assign w_done    = w_access && bus.pready;
    assign w_to      = (TIMEOUT > 0) && w_access && !bus.pready
                       && (r_cnt == TO_LAST);
    assign w_fin     = w_done || w_to;
    assign w_ptr_nxt = (r_idx == LAST_IDX) ? '0 : r_idx + IW'(1);

    // Completion is combinational so the requester sees it in the ACCESS cycle.
    assign bus.req_ready = w_fin ? r_gnt : '0;
    assign bus.rsp_rdata = w_done ? bus.prdata : '0;
    assign bus.rsp_err   = w_done ? bus.pslverr : w_to;

    assign bus.psel    = r_psel;
    assign bus.penable = r_penable;
    assign bus.paddr   = r_paddr;
    assign bus.pwrite  = r_pwrite;
    assign bus.pwdata  = r_pwdata;
    assign bus.pwstrb  = r_pwstrb;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_ptr     <= '0;
            r_idx     <= '0;
            r_gnt     <= '0;
            r_cnt     <= '0;
            r_psel    <= 1'b0;
            r_penable <= 1'b0;
            r_paddr   <= '0;
            r_pwrite  <= 1'b0;
            r_pwdata  <= '0;
            r_pwstrb  <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_state   <= SETUP;
                        r_idx     <= w_idx;
                        r_gnt     <= w_gnt;
                        r_cnt     <= '0;
                        r_psel    <= 1'b1;
                        r_penable <= 1'b0;
                        r_paddr   <= bus.req_addr[w_idx];
                        r_pwrite  <= bus.req_write[w_idx];
                        r_pwdata  <= bus.req_wdata[w_idx];
                        r_pwstrb  <= bus.req_wstrb[w_idx];
                    end
                end
                SETUP: begin
                    r_state   <= ACCESS;
                    r_penable <= 1'b1;
                end
                ACCESS: begin
                    if (w_fin) begin
                        r_state   <= IDLE;
                        r_psel    <= 1'b0;
                        r_penable <= 1'b0;
                        r_ptr     <= w_ptr_nxt;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_core_apb_master.sv
// Scoreboard bench for core_apb_master: two ports, TIMEOUT=4.
// Stimulus queues expected completions; a monitor pops them on req_ready.
module tb_core_apb_master;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    core_apb_master_if #(
        .NUM_PORTS (2),
        .ADDR_W    (32),
        .DATA_W    (32)
    ) bus ();

    core_apb_master #(
        .NUM_PORTS (2),
        .ADDR_W    (32),
        .DATA_W    (32),
        .TIMEOUT   (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int          port;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t        q[$];
    int          done_cyc[$];
    int          tests    = 0;
    int          fails    = 0;
    int          cyc      = 0;
    int          done_cnt = 0;
    int          served[2] = '{0, 0};
    int          seen[2]   = '{0, 0};
    logic        keep_valid = 1'b0;

    logic        slv_stuck = 1'b0;
    logic        slv_err   = 1'b0;
    logic        slv_fixed = 1'b0;
    int          slv_wait  = 0;
    logic [31:0] slv_rdata = '0;
    int          acc       = 0;
    int          c0;
    int          n0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    // APB target: pready after slv_wait ACCESS cycles unless stuck.
    always @(negedge clk) begin
        if (bus.psel && bus.penable) begin
            bus.pready  = !slv_stuck && (acc >= slv_wait);
            bus.prdata  = !bus.pready ? 32'h0 :
                          slv_fixed ? slv_rdata : (bus.paddr ^ 32'hCAFE_0000);
            bus.pslverr = bus.pready && slv_err;
            acc++;
        end else begin
            bus.pready  = 1'b0;
            bus.prdata  = '0;
            bus.pslverr = 1'b0;
            acc         = 0;
        end
    end

    always @(negedge clk) begin
        exp_t e;
        #1;
        if (bus.req_ready != '0) begin
            chk("ready_onehot", 32'($onehot(bus.req_ready)), 32'd1);
            if (q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL sb_unexpected: req_ready=%b, none expected",
                         bus.req_ready);
            end else begin
                e = q.pop_front();
                chk("sb_port", 32'(bus.req_ready), 32'(1) << e.port);
                chk("sb_rdata", bus.rsp_rdata, e.rdata);
                chk("sb_err", 32'(bus.rsp_err), 32'(e.err));
            end
            for (int p = 0; p < 2; p++)
                if (bus.req_ready[p]) served[p]++;
            done_cnt++;
            done_cyc.push_back(cyc);
        end else begin
            chk("idle_rdata", bus.rsp_rdata, 32'h0);
            chk("idle_err", 32'(bus.rsp_err), 32'h0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        for (int p = 0; p < 2; p++) begin
            if (served[p] != seen[p]) begin
                seen[p] = served[p];
                if (!keep_valid) bus.req_valid[p] = 1'b0;
            end
        end
    endtask

    task automatic issue(input int p, input logic [31:0] a, input logic w,
                         input logic [31:0] d, input logic [3:0] s);
        bus.req_addr[p]  = a;
        bus.req_write[p] = w;
        bus.req_wdata[p] = d;
        bus.req_wstrb[p] = s;
        bus.req_valid[p] = 1'b1;
    endtask

    task automatic push(input int p, input logic [31:0] d, input logic e);
        exp_t x;
        x.port  = p;
        x.rdata = d;
        x.err   = e;
        q.push_back(x);
    endtask

    task automatic wait_done(input int n);
        for (int i = 0; i < 60 && done_cnt < n; i++) tick();
        chk("completion_wait", 32'(done_cnt >= n), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.req_valid = '0;
        bus.req_addr  = '0;
        bus.req_write = '0;
        bus.req_wdata = '0;
        bus.req_wstrb = '0;
        rst = 1'b1;
        tick();
        tick();
        chk("rst_psel", 32'(bus.psel), 32'h0);
        chk("rst_penable", 32'(bus.penable), 32'h0);
        chk("rst_paddr", bus.paddr, 32'h0);
        chk("rst_pwrite", 32'(bus.pwrite), 32'h0);
        chk("rst_pwdata", bus.pwdata, 32'h0);
        chk("rst_pwstrb", 32'(bus.pwstrb), 32'h0);
        chk("rst_req_ready", 32'(bus.req_ready), 32'h0);
        chk("rst_rsp_rdata", bus.rsp_rdata, 32'h0);
        chk("rst_rsp_err", 32'(bus.rsp_err), 32'h0);
        rst = 1'b0;
        tick();

        // Single read, port 0, zero wait.
        slv_fixed = 1'b1;
        slv_rdata = 32'hDEAD_BEEF;
        push(0, 32'hDEAD_BEEF, 1'b0);
        issue(0, 32'h0000_1000, 1'b0, 32'h0, 4'hF);
        c0 = cyc;
        tick();
        chk("t1_setup_psel", 32'(bus.psel), 32'h1);
        chk("t1_setup_penable", 32'(bus.penable), 32'h0);
        chk("t1_paddr", bus.paddr, 32'h0000_1000);
        chk("t1_pwrite", 32'(bus.pwrite), 32'h0);
        tick();
        chk("t1_access_psel", 32'(bus.psel), 32'h1);
        chk("t1_access_penable", 32'(bus.penable), 32'h1);
        tick();
        chk("t1_idle_psel", 32'(bus.psel), 32'h0);
        wait_done(1);
        chk("t1_latency", 32'(done_cyc[done_cyc.size()-1] - c0), 32'd2);
        slv_fixed = 1'b0;

        // Write, port 1, three wait states; fields changed after grant.
        slv_wait = 3;
        push(1, 32'hCAFE_2000, 1'b0);
        issue(1, 32'h0000_2000, 1'b1, 32'h1234_5678, 4'b0011);
        c0 = cyc;
        tick();
        chk("t2_pwrite", 32'(bus.pwrite), 32'h1);
        bus.req_addr[1]  = 32'hFFFF_FFFC;
        bus.req_wdata[1] = 32'h0BAD_0BAD;
        bus.req_wstrb[1] = 4'b1100;
        tick();
        for (int k = 0; k < 4; k++) begin
            chk("t2_penable", 32'(bus.penable), 32'h1);
            chk("t2_paddr", bus.paddr, 32'h0000_2000);
            chk("t2_pwdata", bus.pwdata, 32'h1234_5678);
            chk("t2_pwstrb", 32'(bus.pwstrb), 32'h3);
            tick();
        end
        wait_done(2);
        chk("t2_latency", 32'(done_cyc[done_cyc.size()-1] - c0), 32'd5);
        slv_wait = 0;

        // Round-robin, both ports continuously valid.
        keep_valid = 1'b1;
        push(0, 32'hCAFE_0100, 1'b0);
        push(1, 32'hCAFE_0200, 1'b0);
        push(0, 32'hCAFE_0100, 1'b0);
        push(1, 32'hCAFE_0200, 1'b0);
        n0 = done_cnt;
        issue(0, 32'h0000_0100, 1'b0, 32'h0, 4'hF);
        issue(1, 32'h0000_0200, 1'b0, 32'h0, 4'hF);
        wait_done(n0 + 4);
        bus.req_valid = '0;
        keep_valid = 1'b0;
        for (int k = 1; k < 4; k++)
            chk("t3_spacing", 32'(done_cyc[n0+k] - done_cyc[n0+k-1]), 32'd3);
        tick();

        // Timeout with the target stuck.
        slv_stuck = 1'b1;
        push(1, 32'h0, 1'b1);
        issue(1, 32'h0000_3000, 1'b0, 32'h0, 4'hF);
        c0 = cyc;
        wait_done(done_cnt + 1);
        chk("t4_latency", 32'(done_cyc[done_cyc.size()-1] - c0), 32'd5);
        chk("t4_psel_after", 32'(bus.psel), 32'h0);
        slv_stuck = 1'b0;

        // Slave error, then a clean transfer.
        slv_err = 1'b1;
        push(0, 32'hCAFE_4000, 1'b1);
        issue(0, 32'h0000_4000, 1'b0, 32'h0, 4'hF);
        wait_done(done_cnt + 1);
        slv_err = 1'b0;
        push(1, 32'hCAFE_5000, 1'b0);
        issue(1, 32'h0000_5000, 1'b0, 32'h0, 4'hF);
        wait_done(done_cnt + 1);

        // Reset mid-ACCESS with the pointer at port 1.
        push(0, 32'hCAFE_6000, 1'b0);
        issue(0, 32'h0000_6000, 1'b0, 32'h0, 4'hF);
        wait_done(done_cnt + 1);
        slv_stuck = 1'b1;
        issue(1, 32'h0000_7000, 1'b0, 32'h0, 4'hF);
        tick();
        tick();
        chk("t6_in_access", 32'(bus.penable), 32'h1);
        rst = 1'b1;
        issue(0, 32'h0000_8000, 1'b0, 32'h0, 4'hF);
        tick();
        chk("t6_rst_psel", 32'(bus.psel), 32'h0);
        chk("t6_rst_penable", 32'(bus.penable), 32'h0);
        chk("t6_rst_ready", 32'(bus.req_ready), 32'h0);
        rst = 1'b0;
        slv_stuck = 1'b0;
        push(0, 32'hCAFE_8000, 1'b0);
        push(1, 32'hCAFE_7000, 1'b0);
        n0 = done_cnt;
        tick();
        chk("t6_resetup_psel", 32'(bus.psel), 32'h1);
        chk("t6_resetup_penable", 32'(bus.penable), 32'h0);
        chk("t6_resetup_paddr", bus.paddr, 32'h0000_8000);
        wait_done(n0 + 2);
        tick();

        chk("sb_drained", 32'(q.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
